// File: rtl/audio_sample_streamer.sv
// CPU-fed audio sample FIFO with an Avalon-MM register port, drained one sample per
// sample_tick into a DAC stage. Raises a low-water interrupt so the CPU can refill it.
module audio_sample_streamer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LVL_W = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq,
  input  logic        sample_tick,
  output logic [15:0] dac_data,
  output logic        dac_valid
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] LevelFull = LVL_W'(DEPTH);

  localparam logic [1:0] AddrData   = 2'd0;
  localparam logic [1:0] AddrStatus = 2'd1;
  localparam logic [1:0] AddrCtrl   = 2'd2;
  localparam logic [1:0] AddrThresh = 2'd3;

  logic [15:0]      mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, thresh_q;
  logic             enable_q, irq_en_q, underrun_q, overflow_q;
  logic [15:0]      readdata_q, dac_data_q;
  logic             irq_q, dac_valid_q;

  logic        wr, push_req, status_wr, ctrl_wr, thresh_wr, flush;
  logic        pop_req, empty, full, pop, push, overflow_set, underrun_set;
  logic [4:0]  level_field;
  logic [15:0] status, rd_mux;
  logic        unused_wdata;

  assign unused_wdata = ^writedata;

  always_comb begin
    wr        = chipselect & ~write_n;
    push_req  = wr && (address == AddrData);
    status_wr = wr && (address == AddrStatus);
    ctrl_wr   = wr && (address == AddrCtrl);
    thresh_wr = wr && (address == AddrThresh);
    flush     = ctrl_wr && writedata[2];
    pop_req   = sample_tick && enable_q && !flush;
    empty     = (level_q == '0);
    full      = (level_q == LevelFull);
    pop       = pop_req && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    push         = push_req && !flush && (!full || pop);
    overflow_set = push_req && !flush && full && !pop;
    underrun_set = pop_req && empty;
    level_field  = 5'(level_q);
    status       = {7'b0, overflow_q, underrun_q, full, empty, level_field};
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      AddrStatus: rd_mux = status;
      AddrCtrl:   rd_mux = {14'b0, irq_en_q, enable_q};
      AddrThresh: rd_mux = 16'(thresh_q);
      default:    rd_mux = '0;
    endcase
  end

  // Sample storage is not reset; pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= writedata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      thresh_q    <= LVL_W'(4);
      enable_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      underrun_q  <= 1'b0;
      overflow_q  <= 1'b0;
      readdata_q  <= '0;
      dac_data_q  <= '0;
      dac_valid_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      readdata_q  <= rd_mux;
      dac_valid_q <= pop_req;
      irq_q       <= enable_q & irq_en_q & (level_q <= thresh_q);

      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        level_q <= level_q + LVL_W'(push) - LVL_W'(pop);
      end

      if (pop) dac_data_q <= mem_q[rd_ptr_q];

      if (ctrl_wr) begin
        enable_q <= writedata[0];
        irq_en_q <= writedata[1];
      end
      if (thresh_wr) thresh_q <= writedata[LVL_W-1:0];

      // Setting wins over a same-cycle software clear.
      if (underrun_set)                        underrun_q <= 1'b1;
      else if (status_wr && writedata[7])      underrun_q <= 1'b0;
      if (overflow_set)                        overflow_q <= 1'b1;
      else if (status_wr && writedata[8])      overflow_q <= 1'b0;
    end
  end

  assign readdata  = readdata_q;
  assign irq       = irq_q;
  assign dac_data  = dac_data_q;
  assign dac_valid = dac_valid_q;

endmodule

// File: tb/tb_audio_sample_streamer.sv
// Self-checking bench for audio_sample_streamer: a behavioural FIFO model feeds an
// expected-sample queue that is drained whenever the DUT pulses dac_valid.
module tb_audio_sample_streamer;

  localparam int unsigned Depth = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = '0;
  logic [15:0] readdata;
  logic        irq;
  logic        sample_tick = 1'b0;
  logic [15:0] dac_data;
  logic        dac_valid;

  audio_sample_streamer #(.DEPTH(16), .LVL_W(5)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .irq         (irq),
    .sample_tick (sample_tick),
    .dac_data    (dac_data),
    .dac_valid   (dac_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] model_q [$];
  logic [15:0] exp_q [$];
  logic        m_enable, m_irq_en, m_under, m_over;
  logic [15:0] m_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] exp_status();
    int sz = model_q.size();
    return {7'b0, m_over, m_under, (sz == Depth), (sz == 0), 5'(sz)};
  endfunction

  task automatic model_reset();
    model_q.delete();
    exp_q.delete();
    m_enable = 1'b0;
    m_irq_en = 1'b0;
    m_under  = 1'b0;
    m_over   = 1'b0;
    m_last   = '0;
  endtask

  // One bus cycle with an optional write and an optional sample_tick; the model
  // is advanced with the same semantics before the cycle is driven.
  task automatic drive(input bit do_wr, input logic [1:0] addr, input logic [15:0] data,
                       input bit do_tick);
    bit flush = do_wr && addr == 2'd2 && data[2];
    bit pop_req = do_tick && m_enable;
    bit set_under = 0;
    bit set_over = 0;
    if (flush) begin
      model_q.delete();
    end else begin
      if (pop_req) begin
        if (model_q.size() > 0) m_last = model_q.pop_front();
        else set_under = 1;
        exp_q.push_back(m_last);
      end
      if (do_wr && addr == 2'd0) begin
        if (model_q.size() < Depth) model_q.push_back(data);
        else set_over = 1;
      end
      if (do_wr && addr == 2'd1) begin
        if (data[7]) m_under = 1'b0;
        if (data[8]) m_over = 1'b0;
      end
      if (set_under) m_under = 1'b1;
      if (set_over) m_over = 1'b1;
    end
    if (do_wr && addr == 2'd2) begin
      m_enable = data[0];
      m_irq_en = data[1];
    end
    @(negedge clk);
    chipselect  = do_wr;
    write_n     = !do_wr;
    address     = addr;
    writedata   = data;
    sample_tick = do_tick;
    @(posedge clk);
    #1;
    chipselect  = 1'b0;
    write_n     = 1'b1;
    sample_tick = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [1:0] addr, input logic [15:0] exp);
    @(negedge clk);
    address    = addr;
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    check(tag, 32'(readdata), 32'(exp));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_n && dac_valid) begin
      if (exp_q.size() == 0) check("dac_valid_unexpected", 32'(dac_valid), 32'd0);
      else check("dac_data", 32'(dac_data), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_readdata", 32'(readdata), 32'd0);
    check("reset_outputs", {29'd0, irq, dac_valid, |dac_data}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    read_check("reset_status", 2'd1, 16'h0020);
    read_check("reset_thresh", 2'd3, 16'h0004);
    read_check("reset_control", 2'd2, 16'h0000);

    // Basic stream of two samples.
    drive(1, 2'd0, 16'h1234, 0);
    drive(1, 2'd0, 16'h5678, 0);
    drive(1, 2'd2, 16'h0001, 0);
    drive(0, 2'd0, 16'h0000, 1);
    idle(1);
    drive(0, 2'd0, 16'h0000, 1);
    idle(2);
    read_check("stream_status", 2'd1, exp_status());
    check("stream_status_const", 32'(exp_status()), 32'h0020);

    // Underrun on empty, clear, and set-wins-over-clear.
    drive(0, 2'd0, 16'h0000, 1);
    idle(1);
    check("underrun_hold", 32'(dac_data), 32'h5678);
    read_check("underrun_set", 2'd1, exp_status());
    drive(1, 2'd1, 16'h0080, 0);
    read_check("underrun_clear", 2'd1, exp_status());
    drive(1, 2'd1, 16'h0080, 1);
    read_check("underrun_set_wins", 2'd1, exp_status());
    drive(1, 2'd1, 16'h0080, 0);

    // Ticks ignored while disabled.
    drive(1, 2'd2, 16'h0000, 0);
    drive(1, 2'd0, 16'hBEEF, 0);
    drive(0, 2'd0, 16'h0000, 1);
    idle(1);
    read_check("disabled_status", 2'd1, exp_status());
    drive(1, 2'd2, 16'h0005, 0);
    read_check("ctrl_no_flush_bit", 2'd2, 16'h0001);

    // Overflow: 17 writes then drain 16 in order.
    for (int i = 0; i < 17; i++) drive(1, 2'd0, 16'h0100 + 16'(i), 0);
    read_check("overflow_status", 2'd1, exp_status());
    check("overflow_model", 32'(exp_status()), 32'h0150);
    for (int i = 0; i < 16; i++) drive(0, 2'd0, 16'h0000, 1);
    idle(2);
    read_check("drained_status", 2'd1, exp_status());
    drive(1, 2'd1, 16'h0100, 0);
    read_check("overflow_clear", 2'd1, exp_status());

    // Low-water interrupt timing.
    drive(1, 2'd2, 16'h0007, 0);
    drive(1, 2'd3, 16'hFFE4, 0);
    read_check("thresh_masked", 2'd3, 16'h0004);
    for (int i = 0; i < 5; i++) drive(1, 2'd0, 16'h0200 + 16'(i), 0);
    idle(2);
    check("irq_above_thresh", 32'(irq), 32'd0);
    drive(0, 2'd0, 16'h0000, 1);
    check("irq_lag", 32'(irq), 32'd0);
    idle(1);
    check("irq_low_water", 32'(irq), 32'd1);
    drive(1, 2'd0, 16'h0300, 0);
    idle(1);
    check("irq_refilled", 32'(irq), 32'd0);

    // Push+pop at full, then flush with a coincident tick.
    drive(1, 2'd2, 16'h0005, 0);
    for (int i = 0; i < 16; i++) drive(1, 2'd0, 16'h0400 + 16'(i), 0);
    drive(1, 2'd0, 16'hAAAA, 1);
    idle(1);
    read_check("full_push_pop", 2'd1, exp_status());
    check("full_push_pop_model", 32'(exp_status()), 32'h0050);
    drive(1, 2'd2, 16'h0005, 1);
    idle(2);
    read_check("flush_status", 2'd1, exp_status());

    // Asynchronous reset in the middle of a tick.
    for (int i = 0; i < 8; i++) drive(1, 2'd0, 16'h0500 + 16'(i), 0);
    read_check("pre_reset_status", 2'd1, exp_status());
    @(negedge clk);
    address     = 2'd1;
    sample_tick = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_readdata", 32'(readdata), 32'd0);
    check("async_reset_dac_data", 32'(dac_data), 32'd0);
    check("async_reset_flags", {30'd0, irq, dac_valid}, 32'd0);
    sample_tick = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    read_check("post_reset_status", 2'd1, 16'h0020);

    idle(3);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
